// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   It works alongside the ALU in the EX stage. Each start pulse accepted in
//   IDLE launches one operation. The unit then holds busy for a fixed latency
//   that depends on the operation, and writes the result into HI/LO on the
//   last busy cycle. MTHI/MTLO write HI or LO directly in a single edge and do
//   not raise busy.
//
// Ports
//   clk    in   1      clock; all state updates on posedge
//   reset  in   1      synchronous, active-high; aborts any op in flight
//   start  in   1      launch md_op this cycle (ignored while busy)
//   md_op  in   4      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,
//                      6 MSUB,7 MSUBU,8 MTHI,9 MTLO,10-15 no-op
//   src_a  in   WIDTH  rs operand (dividend / multiplicand / MTHI,MTLO data)
//   src_b  in   WIDTH  rt operand (divisor / multiplier)
//   busy   out  1      operation in flight (registered)
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [3:0]         op_q,    op_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic [2*WIDTH-1:0] result;

  // Full 2*WIDTH product. The operands are extended to 2*WIDTH before the
  // multiply, so a plain multiply gives the correct low 2*WIDTH bits for
  // both the signed and the unsigned case.
  function automatic logic [2*WIDTH-1:0] mul_prod(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             is_signed);
    logic [2*WIDTH-1:0] ea, eb;
    ea = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}, which maps directly onto {hi, lo}.
  // Divide-by-zero and the single signed overflow case are resolved here
  // explicitly, so that neither one depends on simulator or synthesis
  // semantics.
  function automatic logic [2*WIDTH-1:0] div_result(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             is_signed);
    logic signed [WIDTH-1:0] sa, sb, sq, sr;
    logic [WIDTH-1:0]        uq, ur;
    sa = a;
    sb = b;
    if (b == '0) begin
      return {a, {WIDTH{1'b1}}};
    end else if (is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}})) begin
      return {{WIDTH{1'b0}}, a};
    end else if (is_signed) begin
      sq = sa / sb;  // truncates toward zero
      sr = sa % sb;  // sign follows dividend
      return {sr, sq};
    end else begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
  endfunction

  // The result is computed from the latched operands and the current HI/LO.
  // It is consumed only on the commit edge. Every even opcode is signed and
  // every odd opcode is unsigned.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    prod   = mul_prod(a_q, b_q, ~op_q[0]);
    acc    = {hi_q, lo_q};
    result = acc;
    case (op_q)
      OP_MULT, OP_MULTU: result = prod;
      OP_DIV,  OP_DIVU:  result = div_result(a_q, b_q, ~op_q[0]);
      OP_MADD, OP_MADDU: result = acc + prod;
      OP_MSUB, OP_MSUBU: result = acc - prod;
      default:           result = acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d = RUN;
              op_d    = md_op;
              a_d     = src_a;
              b_d     = src_b;
              cnt_d   = ((md_op == OP_DIV) || (md_op == OP_DIVU)) ? DIV_LOAD : MULT_LOAD;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Loading LAT-1 and committing on the edge where the counter reads
        // zero keeps busy high for exactly LAT cycles.
        if (cnt_q == '0) begin
          state_d      = IDLE;
          {hi_d, lo_d} = result;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   md_op;
  logic [W-1:0] src_a, src_b;
  logic         busy;
  logic [W-1:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    step();
    start = 1'b0;
  endtask

  // Counts the cycles during which busy is seen high. The count is capped so
  // that a stuck busy still ends the run.
  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy && lat < 200) begin
      lat++;
      step();
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{4'd0, 32'hFFFFFFFD, 32'd7,        32'h0,    32'h0,  32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    32'h0,  32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5,    32'h5,  32'h00000000, 32'h00000001, 5};
    vecs[3]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{4'd3, 32'd7,        32'd0,        32'h0,    32'h0,  32'h00000007, 32'hFFFFFFFF, 10};
    vecs[5]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h9,    32'h9,  32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'h0,    32'h0,  32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{4'd3, 32'hFFFFFFFF, 32'h10,       32'h0,    32'h0,  32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8]  = '{4'd2, 32'hFFFFFFFB, 32'd0,        32'h0,    32'h0,  32'hFFFFFFFB, 32'hFFFFFFFF, 10};
    vecs[9]  = '{4'd5, 32'hFFFFFFFF, 32'd2,        32'h1234, 32'h0,  32'h00001235, 32'hFFFFFFFE, 5};
    vecs[10] = '{4'd4, 32'hFFFFFFFD, 32'd2,        32'h0,    32'h5,  32'hFFFFFFFF, 32'hFFFFFFFF, 5};
    vecs[11] = '{4'd6, 32'd3,        32'd4,        32'h0,    32'h0,  32'hFFFFFFFF, 32'hFFFFFFF4, 5};
    vecs[12] = '{4'd7, 32'hFFFFFFFF, 32'd1,        32'h1,    32'h0,  32'h00000000, 32'h00000001, 5};
    vecs[13] = '{4'd6, 32'hFFFFFFFE, 32'd3,        32'h0,    32'h10, 32'h00000000, 32'h00000016, 5};

    reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    step(); step();
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    // Table-driven vectors. HI/LO are preloaded through MTHI/MTLO.
    for (int i = 0; i < 14; i++) begin
      issue(4'd8, vecs[i].pre_hi, 32'h0);
      check($sformatf("v%0d_mthi_busy", i), {31'b0, busy}, 32'd0);
      issue(4'd9, vecs[i].pre_lo, 32'h0);
      check($sformatf("v%0d_pre_hi", i), hi, vecs[i].pre_hi);
      check($sformatf("v%0d_pre_lo", i), lo, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // A reset held for 2 cycles in the middle of a DIV aborts it; nothing is committed later.
    issue(4'd8, 32'hAAAA, 32'h0);
    issue(4'd9, 32'hBBBB, 32'h0);
    issue(4'd2, 32'd100, 32'd7);
    step(); step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    for (int k = 0; k < 12; k++) step();
    check("rst_nocommit_hi", hi, 32'h0);
    check("rst_nocommit_lo", lo, 32'h0);
    check("rst_nocommit_busy", {31'b0, busy}, 32'd0);

    // Starts issued while busy (MULT, MTLO, MTHI) are ignored. 20/3 gives q=6, r=2.
    issue(4'd2, 32'd20, 32'd3);
    issue(4'd0, 32'd5, 32'd5);
    issue(4'd9, 32'h5555, 32'h0);
    issue(4'd8, 32'h6666, 32'h0);
    check("ign_lo_hold", lo, 32'h0);
    check("ign_hi_hold", hi, 32'h0);
    wait_idle(lat);
    check("ign_lat", lat, 32'd7);
    check("ign_hi", hi, 32'd2);
    check("ign_lo", lo, 32'd6);
    step(); step();
    check("ign_no_mult", {31'b0, busy}, 32'd0);
    check("ign_lo_after", lo, 32'd6);

    // Back-to-back: DIVU 9/2, then MULTU issued in the first cycle busy reads 0.
    issue(4'd3, 32'd9, 32'd2);
    wait_idle(lat);
    check("b2b_hi_first", hi, 32'd1);
    check("b2b_lo_first", lo, 32'd4);
    issue(4'd1, 32'd3, 32'd5);
    check("b2b_accepted", {31'b0, busy}, 32'd1);
    check("b2b_hold_lo", lo, 32'd4);
    wait_idle(lat);
    check("b2b_lat", lat, 32'd5);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd15);

    // Operands are latched: changing src_a/src_b during RUN must not affect the result.
    issue(4'd0, 32'd6, 32'd7);
    src_a = 32'h12345678;
    src_b = 32'hFFFF0000;
    step();
    check("latch_hold_lo", lo, 32'd15);
    wait_idle(lat);
    check("latch_lo", lo, 32'd42);
    check("latch_hi", hi, 32'd0);

    // Reserved opcodes are no-ops.
    issue(4'd12, 32'hDEAD, 32'hBEEF);
    check("noop_busy", {31'b0, busy}, 32'd0);
    check("noop_hi", hi, 32'd0);
    check("noop_lo", lo, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
